// File: rtl/reg_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_pkg
// Shared types and helpers for the register-hazard scoreboard:
//   reg_use_e          - which source registers the decoded instruction reads
//   unit_id_t          - producing functional unit id (default unit count)
//   scoreboard_issue_t - register-related fields of the instruction in decode
//   max_pend()         - largest value a CNT_W-bit pending counter may hold
//   MAX_PEND           - max_pend() evaluated for the default counter width
// -----------------------------------------------------------------------------
package reg_scoreboard_pkg;

    localparam int NUNIT_DEF = 4;
    localparam int CNT_W_DEF = 2;
    localparam int UNIT_W_DEF = (NUNIT_DEF > 1) ? $clog2(NUNIT_DEF) : 1;

    // Source-operand usage of the instruction in decode.
    typedef enum logic [1:0] {
        NO_RS1_RS2   = 2'd0,
        ONLY_RS1     = 2'd1,
        BOTH_RS1_RS2 = 2'd2
    } reg_use_e;

    typedef logic [UNIT_W_DEF-1:0] unit_id_t;

    // Register fields of the decoded instruction. The producing unit id is
    // carried next to this struct because its width follows NUNIT.
    typedef struct packed {
        logic       valid;
        reg_use_e   use_type;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       wen;
        logic [4:0] dst;
    } scoreboard_issue_t;

    // Saturation point of a pending counter of the given width.
    function automatic int max_pend(input int cnt_w);
        return (32'sd1 << cnt_w) - 32'sd1;
    endfunction

    localparam int MAX_PEND = max_pend(CNT_W_DEF);

endpackage : reg_scoreboard_pkg

// File: rtl/reg_scoreboard_if.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_if
// Decode / writeback bundle of the register scoreboard.
//   master : decode + retirement side (drives issue_*, flush, wb_*)
//   slave  : the scoreboard (drives issue_ready, stall, rs*_pending,
//            rs*_unit, busy_mask, wb_err)
// wb_dst packs port k's destination at bits [k*5 +: 5].
// -----------------------------------------------------------------------------
interface reg_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int NWB   = 2,
    parameter int NUNIT = 4
);
    localparam int UNIT_W = (NUNIT > 1) ? $clog2(NUNIT) : 1;

    logic              flush;
    logic              issue_valid;
    logic [1:0]        issue_use;
    logic [4:0]        issue_rs1;
    logic [4:0]        issue_rs2;
    logic              issue_wen;
    logic [4:0]        issue_dst;
    logic [UNIT_W-1:0] issue_unit;
    logic              issue_ready;
    logic              stall;
    logic              rs1_pending;
    logic              rs2_pending;
    logic [UNIT_W-1:0] rs1_unit;
    logic [UNIT_W-1:0] rs2_unit;
    logic [NWB-1:0]    wb_valid;
    logic [NWB*5-1:0]  wb_dst;
    logic [NREG-1:0]   busy_mask;
    logic              wb_err;

    modport master (
        output flush, issue_valid, issue_use, issue_rs1, issue_rs2,
               issue_wen, issue_dst, issue_unit, wb_valid, wb_dst,
        input  issue_ready, stall, rs1_pending, rs2_pending,
               rs1_unit, rs2_unit, busy_mask, wb_err
    );

    modport slave (
        input  flush, issue_valid, issue_use, issue_rs1, issue_rs2,
               issue_wen, issue_dst, issue_unit, wb_valid, wb_dst,
        output issue_ready, stall, rs1_pending, rs2_pending,
               rs1_unit, rs2_unit, busy_mask, wb_err
    );

endinterface : reg_scoreboard_if

// File: rtl/reg_scoreboard_sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
// Pending-write counter for one architectural register.
//   clk, reset : core clock, synchronous active-high reset
//   flush      : clears the count (wins over inc/dec)
//   inc        : one write issued to this register this cycle
//   dec        : number of writeback hits on this register this cycle
//   count      : registered pending count
//   underflow  : this cycle retires more writes than were outstanding
// A write issued in the same cycle cannot be the one being retired, so
// underflow compares dec with the current count only; on underflow the
// old writes clamp to zero and the new issue (if any) still counts.
// -----------------------------------------------------------------------------
module sb_counter #(
    parameter int CNT_W = 2,
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    output logic [CNT_W-1:0] count,
    output logic             underflow
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             underflow_s;

    // Net update: count + inc - dec with clamping at zero.
    always_comb begin
        count_next_s = count_r;
        underflow_s  = 1'b0;
        if (int'(dec) > int'(count_r)) begin
            underflow_s  = 1'b1;
            count_next_s = CNT_W'(int'(inc));
        end else begin
            count_next_s = CNT_W'(int'(count_r) + int'(inc) - int'(dec));
        end
    end

    // Counter register; flush discards all outstanding writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (flush) begin
            count_r <= '0;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count     = count_r;
    assign underflow = underflow_s;

endmodule : sb_counter

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Register-hazard scoreboard between decode and issue/execute.
//   clk   : core clock
//   reset : synchronous, active-high reset
//   sb    : reg_scoreboard_if.slave
//           in : flush, issue_valid/use/rs1/rs2/wen/dst/unit, wb_valid, wb_dst
//           out: issue_ready, stall, rs1/rs2_pending, rs1/rs2_unit,
//                busy_mask, wb_err
// One sb_counter per register 1..NREG-1 tracks outstanding writes; the
// writeback hit count per register feeds both the counters and, when
// WB_BYPASS=1, the combinational pending decision for this cycle.
// -----------------------------------------------------------------------------
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int NWB       = 2,
    parameter int CNT_W     = 2,
    parameter int NUNIT     = 4,
    parameter int WB_BYPASS = 1
) (
    input  logic           clk,
    input  logic           reset,
    reg_scoreboard_if.slave sb
);

    localparam int UNIT_W = (NUNIT > 1) ? $clog2(NUNIT) : 1;
    localparam int HIT_W  = $clog2(NWB + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_pend(CNT_W));

    scoreboard_issue_t iss_s;
    logic [HIT_W-1:0]  hits_s [NREG];
    logic [CNT_W-1:0]  count_s [NREG];
    logic [NREG-1:1]   inc_s;
    logic [NREG-1:0]   underflow_s;
    logic [NREG-1:0]   pend_s;
    logic [UNIT_W-1:0] last_unit_r [NREG];
    logic              wb_err_r;
    logic              rs1_pend_s;
    logic              rs2_pend_s;
    logic              dst_full_s;
    logic              ready_s;
    logic              issue_fire_s;
    logic [4:0]        wb_idx_s;

    assign iss_s.valid    = sb.issue_valid;
    assign iss_s.use_type = reg_use_e'(sb.issue_use);
    assign iss_s.rs1      = sb.issue_rs1;
    assign iss_s.rs2      = sb.issue_rs2;
    assign iss_s.wen      = sb.issue_wen;
    assign iss_s.dst      = sb.issue_dst;

    // Count writeback hits per register; x0 writebacks are ignored.
    always_comb begin
        wb_idx_s = 5'd0;
        for (int r = 0; r < NREG; r++) begin
            hits_s[r] = '0;
        end
        for (int k = 0; k < NWB; k++) begin
            wb_idx_s = sb.wb_dst[k*5 +: 5];
            hits_s[wb_idx_s] = hits_s[wb_idx_s] +
                ((sb.wb_valid[k] && (wb_idx_s != 5'd0)) ? HIT_W'(1) : HIT_W'(0));
        end
    end

    // Effective pending per register, optionally cleared by this cycle's
    // writebacks when they retire every outstanding write.
    always_comb begin
        pend_s = '0;
        for (int r = 1; r < NREG; r++) begin
            if (WB_BYPASS != 0) begin
                pend_s[r] = (count_s[r] != '0) &&
                            (int'(hits_s[r]) < int'(count_s[r]));
            end else begin
                pend_s[r] = (count_s[r] != '0);
            end
        end
    end

    // Issue decision: RAW on used sources, or destination counter full.
    always_comb begin
        rs1_pend_s = 1'b0;
        rs2_pend_s = 1'b0;
        case (iss_s.use_type)
            ONLY_RS1: begin
                rs1_pend_s = pend_s[iss_s.rs1];
            end
            BOTH_RS1_RS2: begin
                rs1_pend_s = pend_s[iss_s.rs1];
                rs2_pend_s = pend_s[iss_s.rs2];
            end
            default: begin
                rs1_pend_s = 1'b0;
                rs2_pend_s = 1'b0;
            end
        endcase
        dst_full_s   = iss_s.wen && (iss_s.dst != 5'd0) &&
                       (count_s[iss_s.dst] == CNT_MAX);
        ready_s      = !rs1_pend_s && !rs2_pend_s && !dst_full_s;
        issue_fire_s = iss_s.valid && ready_s && !sb.flush;
    end

    // One-hot increment towards the destination counter of a fired issue.
    always_comb begin
        inc_s = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_s[r] = issue_fire_s && iss_s.wen && (iss_s.dst == 5'(r));
        end
    end

    assign count_s[0]     = '0;
    assign underflow_s[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_counter #(
            .CNT_W (CNT_W),
            .DEC_W (HIT_W)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .flush     (sb.flush),
            .inc       (inc_s[r]),
            .dec       (hits_s[r]),
            .count     (count_s[r]),
            .underflow (underflow_s[r])
        );
    end

    // Most recent producing unit per register; untouched by flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                last_unit_r[r] <= '0;
            end
        end else if (issue_fire_s && iss_s.wen && (iss_s.dst != 5'd0)) begin
            last_unit_r[iss_s.dst] <= sb.issue_unit;
        end
    end

    // Sticky writeback-underflow flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_err_r <= 1'b0;
        end else begin
            wb_err_r <= wb_err_r | (|underflow_s);
        end
    end

    // Busy mask straight from the registered counters.
    always_comb begin
        sb.busy_mask = '0;
        for (int r = 1; r < NREG; r++) begin
            sb.busy_mask[r] = (count_s[r] != '0);
        end
    end

    assign sb.issue_ready = ready_s;
    assign sb.stall       = iss_s.valid && !ready_s;
    assign sb.rs1_pending = rs1_pend_s;
    assign sb.rs2_pending = rs2_pend_s;
    assign sb.rs1_unit    = last_unit_r[iss_s.rs1];
    assign sb.rs2_unit    = last_unit_r[iss_s.rs2];
    assign sb.wb_err      = wb_err_r;

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
// Directed bench for reg_scoreboard. Two instances share one stimulus
// stream: dut with WB_BYPASS=1 and dut_nb with WB_BYPASS=0.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    reg_scoreboard_if #(.NREG(32), .NWB(2), .NUNIT(4)) sb_if ();
    reg_scoreboard_if #(.NREG(32), .NWB(2), .NUNIT(4)) sb_nb_if ();

    assign sb_nb_if.flush       = sb_if.flush;
    assign sb_nb_if.issue_valid = sb_if.issue_valid;
    assign sb_nb_if.issue_use   = sb_if.issue_use;
    assign sb_nb_if.issue_rs1   = sb_if.issue_rs1;
    assign sb_nb_if.issue_rs2   = sb_if.issue_rs2;
    assign sb_nb_if.issue_wen   = sb_if.issue_wen;
    assign sb_nb_if.issue_dst   = sb_if.issue_dst;
    assign sb_nb_if.issue_unit  = sb_if.issue_unit;
    assign sb_nb_if.wb_valid    = sb_if.wb_valid;
    assign sb_nb_if.wb_dst      = sb_if.wb_dst;

    reg_scoreboard #(.WB_BYPASS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    reg_scoreboard #(.WB_BYPASS(0)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_nb_if)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic v, input logic [1:0] u,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic wen, input logic [4:0] dst,
                               input logic [1:0] unit);
        sb_if.issue_valid = v;
        sb_if.issue_use   = u;
        sb_if.issue_rs1   = rs1;
        sb_if.issue_rs2   = rs2;
        sb_if.issue_wen   = wen;
        sb_if.issue_dst   = dst;
        sb_if.issue_unit  = unit;
    endtask

    task automatic drive_wb(input logic [1:0] v, input logic [4:0] d1,
                            input logic [4:0] d0);
        sb_if.wb_valid = v;
        sb_if.wb_dst   = {d1, d0};
    endtask

    task automatic idle();
        drive_issue(1'b0, NO_RS1_RS2, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0);
        drive_wb(2'b00, 5'd0, 5'd0);
        sb_if.flush = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state.
        check_val("rst_busy", sb_if.busy_mask, 32'h0);
        check_val("rst_err", 32'(sb_if.wb_err), 32'h0);
        check_val("rst_ready", 32'(sb_if.issue_ready), 32'h1);
        check_val("rst_stall", 32'(sb_if.stall), 32'h0);

        // Issue x5 from unit 2, then a dependent read of x5.
        drive_issue(1'b1, NO_RS1_RS2, 5'd0, 5'd0, 1'b1, 5'd5, 2'd2);
        tick();
        drive_issue(1'b1, ONLY_RS1, 5'd5, 5'd0, 1'b0, 5'd0, 2'd0);
        #1;
        check_val("raw_stall", 32'(sb_if.stall), 32'h1);
        check_val("raw_rs1_pend", 32'(sb_if.rs1_pending), 32'h1);
        check_val("raw_rs1_unit", 32'(sb_if.rs1_unit), 32'h2);
        check_val("raw_busy5", 32'(sb_if.busy_mask[5]), 32'h1);
        check_val("raw_rs2_pend", 32'(sb_if.rs2_pending), 32'h0);
        // Writeback of x5 in the same cycle.
        drive_wb(2'b01, 5'd0, 5'd5);
        #1;
        check_val("byp_ready", 32'(sb_if.issue_ready), 32'h1);
        check_val("nobyp_ready", 32'(sb_nb_if.issue_ready), 32'h0);
        tick();
        drive_wb(2'b00, 5'd0, 5'd0);
        #1;
        check_val("nobyp_ready_next", 32'(sb_nb_if.issue_ready), 32'h1);
        check_val("wb5_busy", sb_if.busy_mask, 32'h0);

        // Three writes to x7 fill the counter; a fourth must wait.
        for (int i = 0; i < 3; i++) begin
            drive_issue(1'b1, NO_RS1_RS2, 5'd0, 5'd0, 1'b1, 5'd7, 2'd1);
            #1;
            check_val("waw_ready", 32'(sb_if.issue_ready), 32'h1);
            tick();
        end
        drive_issue(1'b1, NO_RS1_RS2, 5'd0, 5'd0, 1'b1, 5'd7, 2'd1);
        #1;
        check_val("full_ready", 32'(sb_if.issue_ready), 32'h0);
        check_val("full_stall", 32'(sb_if.stall), 32'h1);
        check_val("full_ready_nb", 32'(sb_nb_if.issue_ready), 32'h0);
        tick();
        // Two ports retire x7 together: 3 -> 1, and 2 hits do not clear it.
        drive_issue(1'b1, ONLY_RS1, 5'd7, 5'd0, 1'b0, 5'd0, 2'd0);
        drive_wb(2'b11, 5'd7, 5'd7);
        #1;
        check_val("partial_byp_pend", 32'(sb_if.rs1_pending), 32'h1);
        check_val("x7_unit", 32'(sb_if.rs1_unit), 32'h1);
        tick();
        drive_issue(1'b0, NO_RS1_RS2, 5'd0, 5'd0, 1'b1, 5'd7, 2'd1);
        drive_wb(2'b00, 5'd0, 5'd0);
        #1;
        check_val("dual_wb_busy7", 32'(sb_if.busy_mask[7]), 32'h1);
        check_val("dual_wb_ready", 32'(sb_if.issue_ready), 32'h1);
        drive_issue(1'b1, ONLY_RS1, 5'd7, 5'd0, 1'b0, 5'd0, 2'd0);
        #1;
        check_val("x7_one_pend", 32'(sb_if.rs1_pending), 32'h1);
        drive_wb(2'b01, 5'd0, 5'd7);
        #1;
        check_val("x7_last_byp", 32'(sb_if.issue_ready), 32'h1);
        check_val("x7_last_nb", 32'(sb_nb_if.rs1_pending), 32'h1);
        tick();
        idle();
        #1;
        check_val("x7_clear", sb_if.busy_mask, 32'h0);
        check_val("x7_clear_nb", sb_nb_if.busy_mask, 32'h0);

        // Flush beats a writeback to x9 and an issue to x10.
        drive_issue(1'b1, NO_RS1_RS2, 5'd0, 5'd0, 1'b1, 5'd9, 2'd2);
        tick();
        check_val("x9_busy", sb_if.busy_mask, 32'h0000_0200);
        drive_issue(1'b1, NO_RS1_RS2, 5'd0, 5'd0, 1'b1, 5'd10, 2'd3);
        drive_wb(2'b01, 5'd0, 5'd9);
        sb_if.flush = 1'b1;
        tick();
        idle();
        #1;
        check_val("flush_busy", sb_if.busy_mask, 32'h0);
        check_val("flush_err", 32'(sb_if.wb_err), 32'h0);
        check_val("flush_busy_nb", sb_nb_if.busy_mask, 32'h0);

        // Writeback to idle x12 on port 1: sticky error, count stays 0.
        drive_wb(2'b10, 5'd12, 5'd0);
        #1;
        check_val("uf_err_latency", 32'(sb_if.wb_err), 32'h0);
        tick();
        idle();
        #1;
        check_val("uf_err", 32'(sb_if.wb_err), 32'h1);
        check_val("uf_err_nb", 32'(sb_nb_if.wb_err), 32'h1);
        check_val("uf_busy", sb_if.busy_mask, 32'h0);
        drive_issue(1'b0, NO_RS1_RS2, 5'd0, 5'd0, 1'b1, 5'd12, 2'd0);
        #1;
        check_val("uf_clamp_ready", 32'(sb_if.issue_ready), 32'h1);
        idle();
        tick();
        tick();
        tick();
        check_val("uf_err_hold", 32'(sb_if.wb_err), 32'h1);

        // x0 is never tracked.
        drive_issue(1'b1, BOTH_RS1_RS2, 5'd0, 5'd0, 1'b1, 5'd0, 2'd3);
        #1;
        check_val("x0_ready", 32'(sb_if.issue_ready), 32'h1);
        check_val("x0_rs1_pend", 32'(sb_if.rs1_pending), 32'h0);
        tick();
        tick();
        tick();
        tick();
        idle();
        #1;
        check_val("x0_busy", sb_if.busy_mask, 32'h0);
        check_val("x0_ready_after", 32'(sb_if.issue_ready), 32'h1);

        // rs2 only counts for BOTH_RS1_RS2.
        drive_issue(1'b1, NO_RS1_RS2, 5'd0, 5'd0, 1'b1, 5'd3, 2'd3);
        tick();
        drive_issue(1'b1, ONLY_RS1, 5'd0, 5'd3, 1'b0, 5'd0, 2'd0);
        #1;
        check_val("rs2_ignored", 32'(sb_if.rs2_pending), 32'h0);
        check_val("rs2_ignored_rdy", 32'(sb_if.issue_ready), 32'h1);
        drive_issue(1'b1, BOTH_RS1_RS2, 5'd0, 5'd3, 1'b0, 5'd0, 2'd0);
        #1;
        check_val("rs2_pend", 32'(sb_if.rs2_pending), 32'h1);
        check_val("rs2_unit", 32'(sb_if.rs2_unit), 32'h3);
        check_val("rs2_stall", 32'(sb_if.stall), 32'h1);

        // Reset mid-operation drops pending state and the error flag.
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        #1;
        check_val("mid_rst_busy", sb_if.busy_mask, 32'h0);
        check_val("mid_rst_err", 32'(sb_if.wb_err), 32'h0);
        drive_issue(1'b1, BOTH_RS1_RS2, 5'd0, 5'd3, 1'b0, 5'd0, 2'd0);
        #1;
        check_val("mid_rst_ready", 32'(sb_if.issue_ready), 32'h1);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_scoreboard
